multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It sequences fetch/decode/execute/memory/writeback over the shared datapath. It drives the immediate-extender selector (ext_op), the ALU, PC, IR and register-file strobes, and the imem/dmem request handshakes. It sits beside the datapath and consumes the IR output plus the ALU branch-condition flag.

Parameters:
MEM_TIMEOUT, 255, maximum wait cycles on imem/dmem ready before bus error; 8-bit counter, must be ≥1.

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
instr  in  32  IR contents (valid from DECODE onward)
br_cond  in  1  ALU branch condition true (valid in EXEC)
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
imem_req  out  1  instruction fetch request
dmem_req  out  1  data access request
dmem_we  out  1  data write (stores)
ir_we  out  1  latch fetched word into IR
pc_we  out  1  PC update strobe
pc_sel  out  2  00 pc+4, 01 pc+imm, 10 ALU result & ~1
reg_we  out  1  register-file write strobe
wb_sel  out  2  00 ALU, 01 dmem rdata, 10 pc+4, 11 imm
alu_src_a  out  1  0 rs1, 1 pc
alu_src_b  out  1  0 rs2, 1 imm
alu_op  out  4  ALU operation (package encoding)
ext_op  out  3  immediate format select
trap  out  1  sticky: illegal instruction or bus timeout
state_o  out  3  current state for debug

Behaviour:
- Interface: one clock clk; reset rst_n is synchronous and active-low.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. The state register resets to FETCH and trap resets to 0.
- Outputs are combinational from state and instr. While rst_n=0, every strobe (imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we) is forced 0, and pc_sel, wb_sel, alu_*, ext_op are 0.
- FETCH: imem_req=1 until imem_ready. In the imem_ready cycle, ir_we=1 and the next state is DECODE.
- DECODE: ext_op is valid from the opcode: I-type ALU/load/jalr 000, lui/auipc 001, store 010, branch 011, jal 100, slli/srli/srai 101, anything else 111. An unsupported opcode or funct goes to TRAP, otherwise to EXEC.
- EXEC:
  - Branch: if br_cond, pc_we=1 and pc_sel=01; otherwise pc_we=1 and pc_sel=00. Next state is FETCH.
  - Load/store: next state is MEM.
  - All others: next state is WB.
- MEM: dmem_req=1 and dmem_we=store until dmem_ready. On dmem_ready, a load goes to WB; a store sets pc_we=1, pc_sel=00 and goes to FETCH.
- WB: reg_we=1 and pc_we=1. Then:
  - jal: pc_sel=01, wb_sel=10.
  - jalr: pc_sel=10, wb_sel=10.
  - lui: wb_sel=11.
  - load: wb_sel=01.
  - all others: wb_sel=00, pc_sel=00.
  - Next state is FETCH. reg_we is asserted even when rd=x0; the regfile ignores x0.
- Latency with ready tied high, in cycles: ALU/lui/auipc/jal/jalr 4, branch 3, store 4, load 5.
- Wait counter: cleared on entry to FETCH/MEM and increments each cycle ready is low. When it reaches MEM_TIMEOUT with ready still low, the FSM goes to TRAP.
- TRAP: all strobes 0, trap=1, held until rst_n=0.
- Reset mid-operation: reset in any state, including MEM with dmem_req high, returns to FETCH next cycle with no strobe asserted in the reset cycle.
- Ready asserted in a state that does not request it is ignored.

Decomposition:
- Package ctrl_pkg holds:
  - state enum;
  - EXT_I=000, EXT_U=001, EXT_S=010, EXT_B=011, EXT_J=100, EXT_SH=101, EXT_ZERO=111;
  - opcode constants;
  - ALU_ADD/SUB/AND/OR/XOR/SLL/SRL/SRA/SLT/SLTU/PASSB encodings;
  - pc_sel/wb_sel constants.
- Sub-module: ctrl_decode (combinational opcode/funct → ext_op, alu_op, illegal, instruction class). The FSM instantiates it.

Test Plan:
- addi x1,x0,5 (0x00500093), ready high → ext_op=000 in DECODE, alu_src_b=1, reg_we=1 and wb_sel=00 in cycle 4, pc_sel=00.
- lw x2,8(x1) (0x0080A103), dmem_ready delayed 3 cycles → dmem_req high 4 cycles, dmem_we=0, WB wb_sel=01, total 8 cycles.
- beq x0,x0,+16 (0x00000863) with br_cond=1 → ext_op=011, pc_we=1 and pc_sel=01 in cycle 3, no reg_we. Repeat with br_cond=0 → pc_sel=00.
- slli x3,x3,2 (0x00219193) → ext_op=101. jal x1,+8 (0x008000EF) → ext_op=100, WB pc_sel=01, wb_sel=10.
- instr=0x00000000 → TRAP after DECODE, trap=1, all strobes 0. imem_ready held low → TRAP after 255 wait cycles.
- rst_n low during MEM of a store → dmem_req=0 in that cycle, state FETCH next cycle, trap=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Brief    : Shared types and encodings for the RV32I multi-cycle controller:
//            FSM states, immediate formats, opcodes, ALU operations and the
//            pc/writeback mux selects.
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  // FSM states; the numeric codes are visible on state_o for debug
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  // Instruction class as seen by the sequencer
  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LUI    = 3'd1,
    CLS_JAL    = 3'd2,
    CLS_JALR   = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_LOAD   = 3'd5,
    CLS_STORE  = 3'd6
  } cls_e;

  // Immediate-extender format select
  localparam logic [2:0] EXT_I    = 3'b000;
  localparam logic [2:0] EXT_U    = 3'b001;
  localparam logic [2:0] EXT_S    = 3'b010;
  localparam logic [2:0] EXT_B    = 3'b011;
  localparam logic [2:0] EXT_J    = 3'b100;
  localparam logic [2:0] EXT_SH   = 3'b101;
  localparam logic [2:0] EXT_ZERO = 3'b111;

  // Major opcodes
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // ALU operation encodings
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // PC source select
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  // Register-file writeback select
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  // funct3 (+ the funct7 "alternate" bit) to ALU operation for OP/OP-IMM
  function automatic logic [3:0] alu_from_funct(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode
// Brief    : Combinational instruction decoder. Maps opcode/funct fields to
//            immediate format, ALU operation, ALU operand selects, the
//            instruction class and an illegal-instruction flag.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [2:0]  ext_op_o,
  output logic [3:0]  alu_op_o,
  output logic        alu_src_a_o,
  output logic        alu_src_b_o,
  output logic        illegal_o,
  output cls_e        cls_o
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_unused;

  assign w_opcode = instr_i[6:0];
  assign w_funct3 = instr_i[14:12];
  assign w_funct7 = instr_i[31:25];
  // Register and immediate fields are consumed by the datapath, not here
  assign w_unused = ^{instr_i[24:15], instr_i[11:7]};

  // Opcode/funct decode; anything not listed is illegal
  always_comb begin
    ext_op_o    = EXT_ZERO;
    alu_op_o    = ALU_ADD;
    alu_src_a_o = 1'b0;
    alu_src_b_o = 1'b0;
    illegal_o   = 1'b0;
    cls_o       = CLS_ALU;
    case (w_opcode)
      OP_LUI: begin
        ext_op_o    = EXT_U;
        alu_op_o    = ALU_PASSB;
        alu_src_b_o = 1'b1;
        cls_o       = CLS_LUI;
      end
      OP_AUIPC: begin
        ext_op_o    = EXT_U;
        alu_src_a_o = 1'b1;
        alu_src_b_o = 1'b1;
      end
      OP_JAL: begin
        ext_op_o    = EXT_J;
        alu_src_a_o = 1'b1;
        alu_src_b_o = 1'b1;
        cls_o       = CLS_JAL;
      end
      OP_JALR: begin
        ext_op_o    = EXT_I;
        alu_src_b_o = 1'b1;
        cls_o       = CLS_JALR;
        illegal_o   = (w_funct3 != 3'b000);
      end
      OP_BRANCH: begin
        // The ALU result produces br_cond; its polarity is the datapath's job
        ext_op_o = EXT_B;
        cls_o    = CLS_BRANCH;
        case (w_funct3)
          3'b000, 3'b001: alu_op_o = ALU_SUB;
          3'b100, 3'b101: alu_op_o = ALU_SLT;
          3'b110, 3'b111: alu_op_o = ALU_SLTU;
          default:        illegal_o = 1'b1;
        endcase
      end
      OP_LOAD: begin
        ext_op_o    = EXT_I;
        alu_src_b_o = 1'b1;
        cls_o       = CLS_LOAD;
        illegal_o   = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
      end
      OP_STORE: begin
        ext_op_o    = EXT_S;
        alu_src_b_o = 1'b1;
        cls_o       = CLS_STORE;
        illegal_o   = (w_funct3 > 3'b010);
      end
      OP_IMM: begin
        alu_src_b_o = 1'b1;
        if (w_funct3 == 3'b001) begin
          ext_op_o  = EXT_SH;
          alu_op_o  = ALU_SLL;
          illegal_o = (w_funct7 != 7'b0000000);
        end else if (w_funct3 == 3'b101) begin
          ext_op_o  = EXT_SH;
          alu_op_o  = alu_from_funct(w_funct3, w_funct7[5]);
          illegal_o = (w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000);
        end else begin
          ext_op_o  = EXT_I;
          alu_op_o  = alu_from_funct(w_funct3, 1'b0);
        end
      end
      OP_REG: begin
        alu_op_o  = alu_from_funct(w_funct3, w_funct7[5]);
        illegal_o = !((w_funct7 == 7'b0000000) ||
                      ((w_funct7 == 7'b0100000) &&
                       ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multi-cycle RV32I control FSM. Sequences FETCH/DECODE/EXEC/MEM/
//            WB over a shared datapath, drives datapath selects and strobes,
//            handshakes with imem/dmem and traps on illegal instructions or
//            memory-ready timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        br_cond,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [3:0]  alu_op,
  output logic [2:0]  ext_op,
  output logic        trap,
  output logic [2:0]  state_o
);

  // Timeout fires on the cycle the counter would reach MEM_TIMEOUT
  localparam logic [7:0] C_CNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       trap_q, trap_d;

  logic [2:0] w_ext_op;
  logic [3:0] w_alu_op;
  logic       w_src_a;
  logic       w_src_b;
  logic       w_illegal;
  cls_e       w_cls;

  ctrl_decode u_decode (
    .instr_i     (instr),
    .ext_op_o    (w_ext_op),
    .alu_op_o    (w_alu_op),
    .alu_src_a_o (w_src_a),
    .alu_src_b_o (w_src_b),
    .illegal_o   (w_illegal),
    .cls_o       (w_cls)
  );

  // State, wait counter and sticky trap registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= 8'd0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
    end
  end

  // Next-state and output decode; all outputs are held at 0 during reset
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    trap_d    = trap_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_PLUS4;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = ALU_ADD;
    ext_op    = 3'b000;

    // Decoded datapath controls are only meaningful once IR is loaded
    if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      ext_op    = w_ext_op;
      alu_op    = w_alu_op;
      alu_src_a = w_src_a;
      alu_src_b = w_src_b;
    end

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (cnt_q == C_CNT_LAST) begin
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DECODE: begin
        state_d = w_illegal ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        case (w_cls)
          CLS_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = br_cond ? PC_IMM : PC_PLUS4;
            state_d = S_FETCH;
            cnt_d   = 8'd0;
          end
          CLS_LOAD, CLS_STORE: begin
            state_d = S_MEM;
            cnt_d   = 8'd0;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (w_cls == CLS_STORE);
        if (dmem_ready) begin
          if (w_cls == CLS_STORE) begin
            pc_we   = 1'b1;
            pc_sel  = PC_PLUS4;
            state_d = S_FETCH;
            cnt_d   = 8'd0;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == C_CNT_LAST) begin
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB: begin
        // rd=x0 still strobes reg_we; the regfile discards x0 writes
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        case (w_cls)
          CLS_JAL: begin
            pc_sel = PC_IMM;
            wb_sel = WB_PC4;
          end
          CLS_JALR: begin
            pc_sel = PC_ALU;
            wb_sel = WB_PC4;
          end
          CLS_LUI:  wb_sel = WB_IMM;
          CLS_LOAD: wb_sel = WB_MEM;
          default: begin
            wb_sel = WB_ALU;
            pc_sel = PC_PLUS4;
          end
        endcase
        state_d = S_FETCH;
        cnt_d   = 8'd0;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase

    if (state_d == S_TRAP) begin
      trap_d = 1'b1;
    end

    if (!rst_n) begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      reg_we    = 1'b0;
      pc_sel    = 2'b00;
      wb_sel    = 2'b00;
      alu_src_a = 1'b0;
      alu_src_b = 1'b0;
      alu_op    = 4'd0;
      ext_op    = 3'b000;
    end
  end

  assign trap    = trap_q;
  assign state_o = state_q;

endmodule
`default_nettype wire
